// File: rtl/aes_multiplicative_inv.sv
// Sequential GF(2^8) inverter: computes b^254 mod 0x11B by square-and-multiply,
// one exponent bit per clock, then reports b^-1 and the self-check product b*b^-1.
module aes_multiplicative_inv (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       v_i,
  output logic       ready_o,
  input  logic [7:0] b,
  output logic       v_o,
  output logic [7:0] inv_b,
  output logic [7:0] test_result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam logic [7:0] EXPONENT = 8'hFE;

  // Shift-and-add multiply, reducing by 0x11B each time the shifted operand overflows.
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] a;
    logic [7:0] p;
    a = x;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1B) : {a[6:0], 1'b0};
    end
    return p;
  endfunction

  state_t     r_state;
  logic [7:0] r_b;
  logic [7:0] r_acc;
  logic [2:0] r_cnt;
  logic [7:0] r_inv;
  logic [7:0] r_test;
  logic       r_vo;

  state_t     w_stateNext;
  logic [7:0] w_bNext;
  logic [7:0] w_accNext;
  logic [2:0] w_cntNext;
  logic [7:0] w_invNext;
  logic [7:0] w_testNext;
  logic       w_voNext;

  logic [7:0] w_sq;
  logic [7:0] w_mulA;
  logic [7:0] w_mul;
  logic       w_accept;

  // The single multiplier serves acc^2*b during CALC and acc*b during CHECK.
  assign w_sq     = gmul(r_acc, r_acc);
  assign w_mulA   = (r_state == CHECK) ? r_acc : w_sq;
  assign w_mul    = gmul(w_mulA, r_b);

  assign ready_o  = (r_state == IDLE) && reset_n_i;
  assign w_accept = v_i && ready_o;

  always_comb begin
    w_stateNext = r_state;
    w_bNext     = r_b;
    w_accNext   = r_acc;
    w_cntNext   = r_cnt;
    w_invNext   = r_inv;
    w_testNext  = r_test;
    w_voNext    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_bNext     = b;
          w_accNext   = 8'h01;
          w_cntNext   = 3'd7;
          w_stateNext = CALC;
        end
      end
      CALC: begin
        w_accNext = EXPONENT[r_cnt] ? w_mul : w_sq;
        w_cntNext = r_cnt - 3'd1;
        if (r_cnt == 3'd0) w_stateNext = CHECK;
      end
      CHECK: begin
        w_invNext   = r_acc;
        w_testNext  = w_mul;
        w_voNext    = 1'b1;
        w_stateNext = IDLE;
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= IDLE;
      r_b     <= 8'h00;
      r_acc   <= 8'h01;
      r_cnt   <= 3'd0;
      r_inv   <= 8'h00;
      r_test  <= 8'h00;
      r_vo    <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_b     <= w_bNext;
      r_acc   <= w_accNext;
      r_cnt   <= w_cntNext;
      r_inv   <= w_invNext;
      r_test  <= w_testNext;
      r_vo    <= w_voNext;
    end
  end

  assign v_o         = r_vo;
  assign inv_b       = r_inv;
  assign test_result = r_test;

endmodule

// File: tb/tb_aes_multiplicative_inv.sv
// Bench for aes_multiplicative_inv: a cycle-level reference model built on polynomial
// arithmetic, checked every cycle, plus directed operations with literal expectations.
module tb_aes_multiplicative_inv;

  logic       clk_i     = 1'b0;
  logic       reset_n_i = 1'b0;
  logic       v_i       = 1'b0;
  logic [7:0] b         = 8'h00;
  logic       ready_o;
  logic       v_o;
  logic [7:0] inv_b;
  logic [7:0] test_result;

  int checks   = 0;
  int failures = 0;
  bit checkEn  = 1'b0;

  int         mCnt  = 0;
  logic [7:0] mB    = 8'h00;
  logic       mVo   = 1'b0;
  logic [7:0] mInv  = 8'h00;
  logic [7:0] mTest = 8'h00;

  aes_multiplicative_inv dut (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .v_i         (v_i),
    .ready_o     (ready_o),
    .b           (b),
    .v_o         (v_o),
    .inv_b       (inv_b),
    .test_result (test_result)
  );

  always #5 clk_i = ~clk_i;

  // Full 15-bit polynomial product, then long division by x^8+x^4+x^3+x+1.
  function automatic logic [7:0] refMul(input logic [7:0] x, input logic [7:0] y);
    logic [15:0] p;
    p = 16'h0000;
    for (int i = 0; i < 8; i++)
      if (y[i]) p = p ^ (16'(x) << i);
    for (int k = 14; k >= 8; k--)
      if (p[k]) p = p ^ (16'h011B << (k - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] refInv(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h00;
    for (int y = 1; y < 256; y++)
      if (refMul(x, 8'(y)) == 8'h01) r = 8'(y);
    return r;
  endfunction

  task automatic checkVal(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  // Timing model: idle when mCnt==0, result appears on the 9th edge after accept.
  always @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      mCnt  <= 0;
      mVo   <= 1'b0;
      mInv  <= 8'h00;
      mTest <= 8'h00;
    end else begin
      mVo <= 1'b0;
      if (mCnt == 0) begin
        if (v_i) begin
          mCnt <= 9;
          mB   <= b;
        end
      end else begin
        mCnt <= mCnt - 1;
        if (mCnt == 1) begin
          mVo   <= 1'b1;
          mInv  <= refInv(mB);
          mTest <= refMul(mB, refInv(mB));
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      if (checkEn) begin
        checkVal("ready_o", {7'b0, ready_o}, {7'b0, (mCnt == 0) && reset_n_i});
        checkVal("v_o", {7'b0, v_o}, {7'b0, mVo});
        checkVal("inv_b", inv_b, mInv);
        checkVal("test_result", test_result, mTest);
      end
    end
  end

  // One operation; busy mode keeps v_i high with changing b while the block computes.
  task automatic applyStimulus(input logic [7:0] inB, input bit busy,
                               input logic [7:0] expInv, input logic [7:0] expTest);
    int lat;
    lat = 0;
    @(negedge clk_i);
    checkVal("ready_before_accept", {7'b0, ready_o}, 8'h01);
    v_i = 1'b1;
    b   = inB;
    @(posedge clk_i);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk_i);
      v_i = busy;
      b   = 8'($urandom_range(0, 255));
      @(posedge clk_i);
      #1;
      if (v_o) begin
        lat = n;
        break;
      end
    end
    v_i = 1'b0;
    checkOutput(inB, lat, expInv, expTest);
  endtask

  task automatic checkOutput(input logic [7:0] inB, input int lat,
                             input logic [7:0] expInv, input logic [7:0] expTest);
    checks++;
    if (lat != 9) begin
      failures++;
      $display("[TB] FAIL latency b=0x%02h: got %0d expected 9", inB, lat);
    end
    checkVal("inv_literal", inv_b, expInv);
    checkVal("test_literal", test_result, expTest);
  endtask

  initial begin
    checkVal("model_inv_53", refInv(8'h53), 8'hCA);
    checkVal("model_inv_02", refInv(8'h02), 8'h8D);
    checkVal("model_inv_FF", refInv(8'hFF), 8'h1C);
    checkVal("model_inv_00", refInv(8'h00), 8'h00);
    checkVal("model_mul_57_83", refMul(8'h57, 8'h83), 8'hC1);

    repeat (2) @(posedge clk_i);
    checkEn = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #2;
    checkVal("reset_inv", inv_b, 8'h00);
    checkVal("reset_test", test_result, 8'h00);
    checkVal("reset_vo", {7'b0, v_o}, 8'h00);
    checkVal("reset_ready", {7'b0, ready_o}, 8'h01);

    applyStimulus(8'h01, 1'b0, 8'h01, 8'h01);
    applyStimulus(8'h53, 1'b0, 8'hCA, 8'h01);
    repeat (3) @(posedge clk_i);
    #2;
    checkVal("hold_inv", inv_b, 8'hCA);
    checkVal("hold_test", test_result, 8'h01);
    applyStimulus(8'h02, 1'b0, 8'h8D, 8'h01);
    applyStimulus(8'hFF, 1'b0, 8'h1C, 8'h01);
    applyStimulus(8'h00, 1'b0, 8'h00, 8'h00);
    applyStimulus(8'h53, 1'b1, 8'hCA, 8'h01);
    applyStimulus(8'h02, 1'b0, 8'h8D, 8'h01);
    applyStimulus(8'hFF, 1'b0, 8'h1C, 8'h01);

    for (int x = 1; x < 256; x++) begin
      if (x == 8'h80) begin
        @(negedge clk_i);
        v_i = 1'b1;
        b   = 8'h80;
        @(negedge clk_i);
        v_i = 1'b0;
        repeat (4) @(negedge clk_i);
        reset_n_i = 1'b0;
        #1;
        checkVal("midreset_inv", inv_b, 8'h00);
        checkVal("midreset_test", test_result, 8'h00);
        checkVal("midreset_ready", {7'b0, ready_o}, 8'h00);
        repeat (2) @(negedge clk_i);
        reset_n_i = 1'b1;
        repeat (12) @(posedge clk_i);
        #2;
        checkVal("after_reset_vo", {7'b0, v_o}, 8'h00);
        checkVal("after_reset_inv", inv_b, 8'h00);
      end
      applyStimulus(8'(x), 1'b0, refInv(8'(x)), 8'h01);
    end

    repeat (3) @(posedge clk_i);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
